// File: rtl/shared_bank_rqst_sched_pkg.sv
// Shared definitions for the shared column-bank request scheduler.
// Holds the width localparams, the FSM state encoding and the
// lowest-set-bit helper used by the priority encoder.
package shared_bank_rqst_sched_pkg;

    localparam int SHARED_BANK_NUM           = 5;
    localparam int RQST_ADDR_BITWIDTH        = 2;
    localparam int GP_ELEMENT_ROW_ADDR_WIDTH = 7;
    localparam int CNT_WIDTH                 = 3;
    localparam int IDX_WIDTH                 = $clog2(SHARED_BANK_NUM);
    localparam int ADDR_VEC_WIDTH            = RQST_ADDR_BITWIDTH * SHARED_BANK_NUM;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Two's complement trick: v & -v keeps only the lowest set bit.
    function automatic logic [SHARED_BANK_NUM-1:0] lowest_set_onehot(
        input logic [SHARED_BANK_NUM-1:0] v
    );
        return v & (-v);
    endfunction

endpackage

// File: rtl/shared_bank_rqst_sched_pri_enc.sv
// Lowest-index-first priority encoder over the pending requester vector.
// Ports:
//   i_pending  pending shared-bank requests
//   o_onehot   one-hot lowest set bit (0 when nothing pending)
//   o_idx      binary index of that bit, used for address muxing
//   o_last     the selected bit is the only one still pending
module shared_rqst_pri_enc
    import shared_bank_rqst_sched_pkg::*;
(
    input  logic [SHARED_BANK_NUM-1:0] i_pending,
    output logic [SHARED_BANK_NUM-1:0] o_onehot,
    output logic [IDX_WIDTH-1:0]       o_idx,
    output logic                       o_last
);

    assign o_onehot = lowest_set_onehot(i_pending);
    assign o_last   = ((i_pending & ~o_onehot) == '0);

    always_comb begin
        o_idx = '0;
        for (int i = 0; i < SHARED_BANK_NUM; i++) begin
            if (o_onehot[i]) o_idx = IDX_WIDTH'(i);
        end
    end

endmodule

// File: rtl/shared_bank_rqst_sched.sv
// Per-batch scheduler for the shared column banks. A batch of share flags,
// per-requester column addresses and a row offset is accepted in IDLE.
// Requesters with flag 0 get a one-cycle gp1 enable; requesters with flag 1
// are serialised lowest-index-first onto the shared port (valid/ready).
// Ports:
//   sys_clk, rstn              clock, async active-low reset
//   rqst_valid_i/rqst_ready_o  batch handshake
//   share_rqstFlag_i           per-requester shared-bank flag
//   rqst_addr_i, row_addr_i    batch column addresses and row offset
//   gp1_en_o                   one-cycle enable for non-shared requesters
//   gp2_*                      shared-port request (valid/ready, grant, addresses)
//   issue_cnt_o                shared accesses completed in current batch
//   batch_done_o, busy_o       end-of-batch pulse, not-idle status
module shared_bank_rqst_sched
    import shared_bank_rqst_sched_pkg::*;
(
    input  logic                                 sys_clk,
    input  logic                                 rstn,
    input  logic                                 rqst_valid_i,
    output logic                                 rqst_ready_o,
    input  logic [SHARED_BANK_NUM-1:0]           share_rqstFlag_i,
    input  logic [ADDR_VEC_WIDTH-1:0]            rqst_addr_i,
    input  logic [GP_ELEMENT_ROW_ADDR_WIDTH-1:0] row_addr_i,
    output logic [SHARED_BANK_NUM-1:0]           gp1_en_o,
    output logic                                 gp2_valid_o,
    input  logic                                 gp2_ready_i,
    output logic [SHARED_BANK_NUM-1:0]           gp2_grant_o,
    output logic [RQST_ADDR_BITWIDTH-1:0]        gp2_addr_o,
    output logic [GP_ELEMENT_ROW_ADDR_WIDTH-1:0] gp2_row_addr_o,
    output logic [CNT_WIDTH-1:0]                 issue_cnt_o,
    output logic                                 batch_done_o,
    output logic                                 busy_o
);

    state_t                             r_state, w_state_nxt;
    logic [SHARED_BANK_NUM-1:0]         r_pending;
    logic [ADDR_VEC_WIDTH-1:0]          r_addr;
    logic [GP_ELEMENT_ROW_ADDR_WIDTH-1:0] r_row;
    logic [CNT_WIDTH-1:0]               r_cnt;
    logic [SHARED_BANK_NUM-1:0]         r_gp1_en;

    logic [SHARED_BANK_NUM-1:0]         w_onehot;
    logic [IDX_WIDTH-1:0]               w_idx;
    logic                               w_last;
    logic                               w_accept;
    logic                               w_fire;

    shared_rqst_pri_enc u_pri_enc (
        .i_pending (r_pending),
        .o_onehot  (w_onehot),
        .o_idx     (w_idx),
        .o_last    (w_last)
    );

    assign w_accept = (r_state == IDLE)  && rqst_valid_i;
    assign w_fire   = (r_state == ISSUE) && gp2_ready_i;

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (rqst_valid_i) w_state_nxt = (share_rqstFlag_i != '0) ? ISSUE : DONE;
            ISSUE:   if (gp2_ready_i && w_last) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Pending/address/row are only loaded on acceptance, so the granted
    // requester and its addresses hold steady under backpressure.
    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            r_pending <= '0;
            r_addr    <= '0;
            r_row     <= '0;
            r_cnt     <= '0;
            r_gp1_en  <= '0;
        end else begin
            r_gp1_en <= w_accept ? ~share_rqstFlag_i : '0;
            if (w_accept) begin
                r_pending <= share_rqstFlag_i;
                r_addr    <= rqst_addr_i;
                r_row     <= row_addr_i;
                r_cnt     <= '0;
            end else if (w_fire) begin
                r_pending <= r_pending & ~w_onehot;
                r_cnt     <= r_cnt + 1'b1;
            end
        end
    end

    assign rqst_ready_o   = (r_state == IDLE);
    assign busy_o         = (r_state != IDLE);
    assign batch_done_o   = (r_state == DONE);
    assign gp2_valid_o    = (r_state == ISSUE);
    assign gp2_grant_o    = gp2_valid_o ? w_onehot : '0;
    assign gp2_addr_o     = gp2_valid_o ? r_addr[w_idx*RQST_ADDR_BITWIDTH +: RQST_ADDR_BITWIDTH] : '0;
    assign gp2_row_addr_o = r_row;
    assign issue_cnt_o    = r_cnt;
    assign gp1_en_o       = r_gp1_en;

endmodule

// File: doc/shared_bank_rqst_sched.md
# shared_bank_rqst_sched

Per-batch scheduler for the partially-parallelised (shared) column banks. It consumes one batch of shared-group request flags, requester column addresses and a row address offset from the access request generator. Shared-group requesters are serialised onto the single shared bank port with a valid/ready handshake. Fully-parallelised requesters receive a one-cycle enable. The block sits between the access request generator and the shared column-bank / IB-LUT memory port.

## Interface
- SHARED_BANK_NUM, 5: requesters per share group (GP1+GP2).
- RQST_ADDR_BITWIDTH, 2: column address width per requester.
- GP_ELEMENT_ROW_ADDR_WIDTH, 7: row address offset width.
- CNT_WIDTH, 3: width of issue counter; must satisfy 2^CNT_WIDTH > SHARED_BANK_NUM.

Ports:
- sys_clk  in  1  sole clock, rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- rqst_valid_i  in  1  batch offered.
- rqst_ready_o  out  1  batch accepted when valid&ready.
- share_rqstFlag_i  in  SHARED_BANK_NUM  '1' means the requester needs the shared bank.
- rqst_addr_i  in  RQST_ADDR_BITWIDTH*SHARED_BANK_NUM  concatenated column addresses; requester i occupies bits [i*A +: A].
- row_addr_i  in  GP_ELEMENT_ROW_ADDR_WIDTH  row offset of the batch.
- gp1_en_o  out  SHARED_BANK_NUM  one-cycle enable for requesters whose flag is 0.
- gp2_valid_o  out  1  shared-port request valid.
- gp2_ready_i  in  1  shared port accepts.
- gp2_grant_o  out  SHARED_BANK_NUM  one-hot granted requester.
- gp2_addr_o  out  RQST_ADDR_BITWIDTH  column address of the granted requester.
- gp2_row_addr_o  out  GP_ELEMENT_ROW_ADDR_WIDTH  latched row offset.
- issue_cnt_o  out  CNT_WIDTH  shared accesses completed in the current batch.
- batch_done_o  out  1  one-cycle pulse at batch end.
- busy_o  out  1  high when not IDLE.

## Operation
- FSM states are IDLE, ISSUE and DONE.
- IDLE:
  - rqst_ready_o=1.
  - On rqst_valid_i, latch flags into a pending register, and latch the addresses and row offset. Clear issue_cnt_o.
  - Next state is ISSUE if flags≠0, otherwise DONE.
- gp1_en_o equals the bitwise inverse of the latched flags for exactly the first cycle after acceptance. It is 0 at all other times.
- ISSUE:
  - gp2_valid_o=1.
  - gp2_grant_o is the lowest set bit of pending. gp2_addr_o is the address slice of that requester.
  - On gp2_valid_o&gp2_ready_i: clear that pending bit and increment issue_cnt_o.
  - When the cleared bit was the last one, go to DONE.
- DONE: batch_done_o=1 for one cycle, then go to IDLE.
- gp2_grant_o, gp2_addr_o and gp2_row_addr_o stay stable while gp2_valid_o=1 and gp2_ready_i=0.
- gp2_ready_i is ignored when gp2_valid_o=0. rqst_valid_i is ignored outside IDLE, so input changes while busy have no effect.
- Outside ISSUE, gp2_grant_o=0 and gp2_valid_o=0.

## Timing
- Reset values:
  - state=IDLE, rqst_ready_o=1, busy_o=0.
  - gp1_en_o, gp2_valid_o, gp2_grant_o, gp2_addr_o, gp2_row_addr_o, issue_cnt_o and batch_done_o are all 0.
- rstn asserted mid-batch aborts immediately. Pending grants are discarded and no batch_done_o is produced.
- Batch accepted at cycle T with k flags set and gp2_ready_i held high:
  - grants at T+1…T+k.
  - batch_done_o at T+k+1.
  - next acceptance no earlier than T+k+2.
- k=0: gp1_en_o and batch_done_o both at T+1.
- Each cycle with gp2_ready_i=0 in ISSUE adds one cycle of latency.
- All outputs are registered. The only combinational dependency of an output on an input is none: gp2_grant_o and gp2_addr_o derive from registered pending state.
- issue_cnt_o holds its final value until the next acceptance.

## Structure
- Shared package contains:
  - state encoding: IDLE=2'd0, ISSUE=2'd1, DONE=2'd2.
  - SHARED_BANK_NUM and width localparams.
  - function lowest_set_onehot.
- Sub-module shared_rqst_pri_enc:
  - input: pending vector.
  - outputs: one-hot lowest set bit, its binary index (for address muxing), and a flag marking it as the last set bit.
- Top level contains the FSM, pending/address/row registers and issue counter.

## Test plan
- Reset: assert rstn=0 mid-ISSUE with flags 5'b10100 -> all outputs reach reset values asynchronously; after release rqst_ready_o=1 and no batch_done_o.
- Flags=5'b10100, addr={2'd3,2'd2,2'd1,2'd0,2'd3}, row=7'd42, gp2_ready_i=1:
  - T+1: gp1_en_o=5'b01011, grant=5'b00100, addr=2'd1, row=42.
  - T+2: grant=5'b10000, addr=2'd3.
  - T+3: batch_done_o=1, issue_cnt_o=2.
- Backpressure: same batch with gp2_ready_i low for 3 cycles on the first grant -> grant, addr and row held stable; batch_done_o arrives 3 cycles later.
- Flags=5'b00000 -> T+1: gp1_en_o=5'b11111, batch_done_o=1, gp2_valid_o never high.
- Flags=5'b11111 back-to-back with a second batch offered while busy -> grants in order 0…4; the second batch is accepted only in IDLE, at T+7.
